// File: rtl/traffic_pkg.sv
// Shared phase encodings, lamp codes and interval conversion for the intersection sequencer.
package traffic_pkg;

  typedef enum logic [2:0] {
    RED_TO_NS = 3'd0,
    NS_GREEN  = 3'd1,
    NS_YELLOW = 3'd2,
    RED_TO_EW = 3'd3,
    EW_GREEN  = 3'd4,
    EW_YELLOW = 3'd5
  } phase_e;

  localparam logic [2:0] LIGHT_RED = 3'b100;
  localparam logic [2:0] LIGHT_YEL = 3'b010;
  localparam logic [2:0] LIGHT_GRN = 3'b001;

  // A zero-length interval would never expire through the count==1 rule, so clamp to 1.
  function automatic longint ms_to_cycles(input longint ms, input longint clk_freq);
    longint cyc;
    cyc = (ms * clk_freq) / 64'sd1000;
    return (cyc < 64'sd1) ? 64'sd1 : cyc;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Per-phase down-counter: expires on the cycle it reads 1, then saturates at 0.
module phase_timer #(
  parameter int                 DELAY_W = 32,
  parameter logic [DELAY_W-1:0] RST_VAL = DELAY_W'(1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [DELAY_W-1:0] load_val,
  input  logic               hold,
  output logic [DELAY_W-1:0] count,
  output logic               expire
);

  localparam logic [DELAY_W-1:0] ONE = DELAY_W'(1);

  logic [DELAY_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (!hold && (count_q != '0)) begin
      count_d = count_q - ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= RST_VAL;
    end else begin
      count_q <= count_d;
    end
  end

  assign count  = count_q;
  assign expire = (count_q == ONE) && !hold;

endmodule

// File: rtl/intersection_phase_sequencer.sv
// Two-way intersection phase sequencer with yellow/all-red clearance and rest-in-green.
// Optional EMERGENCY_PREEMPT_EN adds the preempt input that forces and holds all-red.
module intersection_phase_sequencer
  import traffic_pkg::*;
#(
  parameter int CLK_FREQ      = 50_000_000,
  parameter int YELLOW_MS     = 30,
  parameter int ALL_RED_MS    = 10,
  parameter int REST_IN_GREEN = 1,
  parameter int DELAY_W       = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DELAY_W-1:0] ns_green_delay,
  input  logic [DELAY_W-1:0] ew_green_delay,
  input  logic               ns_sensor,
  input  logic               ew_sensor,
`ifdef EMERGENCY_PREEMPT_EN
  input  logic               preempt,
`endif
  output logic [2:0]         ns_light,
  output logic [2:0]         ew_light,
  output logic [2:0]         phase,
  output logic               phase_done
);

  localparam logic [DELAY_W-1:0] ONE         = DELAY_W'(1);
  localparam logic [DELAY_W-1:0] YELLOW_CYC  = DELAY_W'(ms_to_cycles(YELLOW_MS, CLK_FREQ));
  localparam logic [DELAY_W-1:0] ALL_RED_CYC = DELAY_W'(ms_to_cycles(ALL_RED_MS, CLK_FREQ));

  function automatic logic [DELAY_W-1:0] green_len(input logic [DELAY_W-1:0] d);
    return (d == '0) ? ONE : d;
  endfunction

  function automatic logic [2:0] ns_lamp(input phase_e s);
    case (s)
      NS_GREEN:  return LIGHT_GRN;
      NS_YELLOW: return LIGHT_YEL;
      default:   return LIGHT_RED;
    endcase
  endfunction

  function automatic logic [2:0] ew_lamp(input phase_e s);
    case (s)
      EW_GREEN:  return LIGHT_GRN;
      EW_YELLOW: return LIGHT_YEL;
      default:   return LIGHT_RED;
    endcase
  endfunction

  logic pre;
`ifdef EMERGENCY_PREEMPT_EN
  assign pre = preempt;
`else
  assign pre = 1'b0;
`endif

  phase_e             state_q, state_d;
  logic [2:0]         ns_light_q, ns_light_d, ew_light_q, ew_light_d;
  logic               phase_done_q, phase_done_d;
  logic               tmr_load, tmr_hold, tmr_expire;
  logic [DELAY_W-1:0] tmr_load_val, tmr_count;
  logic               green_out, ns_go, ew_go;

  phase_timer #(
    .DELAY_W (DELAY_W),
    .RST_VAL (ALL_RED_CYC)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .hold     (tmr_hold),
    .count    (tmr_count),
    .expire   (tmr_expire)
  );

  // A resting green sits with the timer at 0 until the opposing approach calls.
  assign green_out = tmr_expire || (tmr_count == '0);
  assign ns_go     = pre || (green_out && ((REST_IN_GREEN == 0) || ew_sensor));
  assign ew_go     = pre || (green_out && ((REST_IN_GREEN == 0) || ns_sensor));

  always_comb begin
    state_d      = state_q;
    tmr_load     = 1'b0;
    tmr_load_val = ALL_RED_CYC;
    tmr_hold     = 1'b0;
    case (state_q)
      RED_TO_NS: begin
        // Preempt keeps reloading the clearance so a full all-red follows its release.
        if (pre) begin
          tmr_load = 1'b1;
          tmr_hold = 1'b1;
        end else if (tmr_expire) begin
          state_d      = NS_GREEN;
          tmr_load     = 1'b1;
          tmr_load_val = green_len(ns_green_delay);
        end
      end
      NS_GREEN: begin
        if (ns_go) begin
          state_d      = NS_YELLOW;
          tmr_load     = 1'b1;
          tmr_load_val = YELLOW_CYC;
        end
      end
      NS_YELLOW: begin
        if (tmr_expire) begin
          state_d  = RED_TO_EW;
          tmr_load = 1'b1;
        end
      end
      RED_TO_EW: begin
        if (pre) begin
          tmr_load = 1'b1;
          tmr_hold = 1'b1;
        end else if (tmr_expire) begin
          state_d      = EW_GREEN;
          tmr_load     = 1'b1;
          tmr_load_val = green_len(ew_green_delay);
        end
      end
      EW_GREEN: begin
        if (ew_go) begin
          state_d      = EW_YELLOW;
          tmr_load     = 1'b1;
          tmr_load_val = YELLOW_CYC;
        end
      end
      EW_YELLOW: begin
        if (tmr_expire) begin
          state_d  = RED_TO_NS;
          tmr_load = 1'b1;
        end
      end
      default: begin
        state_d  = RED_TO_NS;
        tmr_load = 1'b1;
      end
    endcase
    phase_done_d = (state_d != state_q);
    ns_light_d   = ns_lamp(state_d);
    ew_light_d   = ew_lamp(state_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= RED_TO_NS;
      ns_light_q   <= LIGHT_RED;
      ew_light_q   <= LIGHT_RED;
      phase_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ns_light_q   <= ns_light_d;
      ew_light_q   <= ew_light_d;
      phase_done_q <= phase_done_d;
    end
  end

  assign phase      = state_q;
  assign ns_light   = ns_light_q;
  assign ew_light   = ew_light_q;
  assign phase_done = phase_done_q;

endmodule

// File: tb/tb_intersection_phase_sequencer.sv
// Randomised bench for intersection_phase_sequencer against an elapsed-time phase model.
module tb_intersection_phase_sequencer;

  localparam int CLK_FREQ   = 1000;
  localparam int YELLOW_MS  = 3;
  localparam int ALL_RED_MS = 2;
  localparam int REST       = 1;
  localparam int DW         = 32;
  localparam int YEL_LEN    = 3;
  localparam int AR_LEN     = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] ns_d, ew_d;
  logic          ns_s, ew_s, preempt;
  logic [2:0]    ns_light, ew_light, phase;
  logic          phase_done;
  logic [9:0]    dut_vec;

  int   n_cmp = 0;
  int   n_err = 0;
  int   m_ph, m_age, m_dur;
  logic m_done;

  always #5 clk = ~clk;

  assign dut_vec = {phase, ns_light, ew_light, phase_done};

  intersection_phase_sequencer #(
    .CLK_FREQ      (CLK_FREQ),
    .YELLOW_MS     (YELLOW_MS),
    .ALL_RED_MS    (ALL_RED_MS),
    .REST_IN_GREEN (REST),
    .DELAY_W       (DW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ns_green_delay (ns_d),
    .ew_green_delay (ew_d),
    .ns_sensor      (ns_s),
    .ew_sensor      (ew_s),
`ifdef EMERGENCY_PREEMPT_EN
    .preempt        (preempt),
`endif
    .ns_light       (ns_light),
    .ew_light       (ew_light),
    .phase          (phase),
    .phase_done     (phase_done)
  );

  // Model: which of the six phases we are in, how many cycles spent there, how long it should last.
  function automatic int green_len(input logic [DW-1:0] d);
    return (d == 0) ? 1 : int'(d);
  endfunction

  task automatic model_reset();
    m_ph = 0; m_age = 0; m_dur = AR_LEN; m_done = 1'b0;
  endtask

  task automatic model_step();
    bit leave;
    bit served;
    served = (m_age + 1 >= m_dur);
    case (m_ph)
      0, 3:    leave = !preempt && served;
      1:       leave = preempt || (served && (REST == 0 || ew_s));
      4:       leave = preempt || (served && (REST == 0 || ns_s));
      default: leave = served;
    endcase
    if (leave) begin
      m_ph   = (m_ph + 1) % 6;
      m_age  = 0;
      m_done = 1'b1;
      case (m_ph)
        1:       m_dur = green_len(ns_d);
        4:       m_dur = green_len(ew_d);
        2, 5:    m_dur = YEL_LEN;
        default: m_dur = AR_LEN;
      endcase
    end else begin
      m_done = 1'b0;
      if ((m_ph == 0 || m_ph == 3) && preempt) m_age = 0;
      else m_age = m_age + 1;
    end
  endtask

  function automatic logic [9:0] exp_vec();
    logic [2:0] ns_e, ew_e, ph;
    ph   = m_ph[2:0];
    ns_e = (m_ph == 1) ? 3'b001 : (m_ph == 2) ? 3'b010 : 3'b100;
    ew_e = (m_ph == 4) ? 3'b001 : (m_ph == 5) ? 3'b010 : 3'b100;
    return {ph, ns_e, ew_e, m_done};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; ns_d = 5; ew_d = 5; ns_s = 1'b1; ew_s = 1'b1; preempt = 1'b0;
    model_reset();
    #3;
    n_cmp++;
    if (dut_vec !== 10'b000_100_100_0) begin
      n_err++; $display("FAIL reset_async got=%b exp=%b", dut_vec, 10'b000_100_100_0);
    end
    @(negedge clk);
    tick(); tick();
    n_cmp++;
    if (dut_vec !== exp_vec()) begin
      n_err++; $display("FAIL reset_held got=%b exp=%b", dut_vec, exp_vec());
    end
    rst = 1'b0;
  endtask

  task automatic test_basic_cycle();
    int first, second;
    first = -1; second = -1;
    for (int i = 0; i < 45; i++) begin
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL basic cyc=%0d got=%b exp=%b", i, dut_vec, exp_vec());
      end
      if (phase == 3'd0 && phase_done) begin
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
      tick();
    end
    n_cmp++;
    if (second - first != 20) begin
      n_err++; $display("FAIL basic_period got=%0d exp=20", second - first);
    end
  endtask

  task automatic test_delay_change();
    int len;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 60 && !(phase == 3'd1 && phase_done); i++) begin
        n_cmp++;
        if (dut_vec !== exp_vec()) begin
          n_err++; $display("FAIL delay_wait got=%b exp=%b", dut_vec, exp_vec());
        end
        tick();
      end
      n_cmp++;
      if (!(phase == 3'd1 && phase_done)) begin
        n_err++; $display("FAIL delay_entry got phase=%0d done=%b exp phase=1 done=1", phase, phase_done);
      end
      len = 0;
      for (int i = 0; i < 40 && phase == 3'd1; i++) begin
        n_cmp++;
        if (dut_vec !== exp_vec()) begin
          n_err++; $display("FAIL delay_green got=%b exp=%b", dut_vec, exp_vec());
        end
        len++;
        if (len == 3) ns_d = 9;
        tick();
      end
      n_cmp++;
      if (len != ((pass == 0) ? 5 : 9)) begin
        n_err++; $display("FAIL delay_len pass=%0d got=%0d exp=%0d", pass, len, (pass == 0) ? 5 : 9);
      end
    end
    ns_d = 5;
  endtask

  task automatic test_zero_delay();
    int len;
    ew_d = 0;
    for (int i = 0; i < 60 && !(phase == 3'd4 && phase_done); i++) begin
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL zero_wait got=%b exp=%b", dut_vec, exp_vec());
      end
      tick();
    end
    len = 0;
    for (int i = 0; i < 40 && phase == 3'd4; i++) begin
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL zero_green got=%b exp=%b", dut_vec, exp_vec());
      end
      len++;
      tick();
    end
    n_cmp++;
    if (len != 1) begin
      n_err++; $display("FAIL zero_len got=%0d exp=1", len);
    end
    ew_d = 5;
  endtask

  task automatic test_rest_in_green();
    ns_d = 4; ew_s = 1'b0;
    for (int i = 0; i < 60 && !(phase == 3'd1 && phase_done); i++) begin
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL rest_wait got=%b exp=%b", dut_vec, exp_vec());
      end
      tick();
    end
    for (int c = 1; c <= 20; c++) begin
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL rest_model cyc=%0d got=%b exp=%b", c, dut_vec, exp_vec());
      end
      if (c > 1) begin
        n_cmp++;
        if (phase !== 3'd1 || phase_done !== 1'b0) begin
          n_err++; $display("FAIL rest_hold cyc=%0d got phase=%0d done=%b exp phase=1 done=0", c, phase, phase_done);
        end
      end
      if (c == 20) ew_s = 1'b1;
      else ns_s = 1'($urandom_range(0, 1));
      tick();
    end
    n_cmp++;
    if (phase !== 3'd2 || phase_done !== 1'b1) begin
      n_err++; $display("FAIL rest_release got phase=%0d done=%b exp phase=2 done=1", phase, phase_done);
    end
    ns_s = 1'b1; ns_d = 5;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 60 && phase != 3'd2; i++) begin
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL arst_wait got=%b exp=%b", dut_vec, exp_vec());
      end
      tick();
    end
    #2 rst = 1'b1;
    #1;
    model_reset();
    n_cmp++;
    if (dut_vec !== 10'b000_100_100_0) begin
      n_err++; $display("FAIL arst_immediate got=%b exp=%b", dut_vec, 10'b000_100_100_0);
    end
    @(negedge clk);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL arst_release cyc=%0d got=%b exp=%b", i, dut_vec, exp_vec());
      end
      tick();
    end
    n_cmp++;
    if (phase !== 3'd1 || phase_done !== 1'b1) begin
      n_err++; $display("FAIL arst_allred got phase=%0d done=%b exp phase=1 done=1", phase, phase_done);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL random cyc=%0d got=%b exp=%b", i, dut_vec, exp_vec());
      end
      ns_s = ($urandom_range(0, 3) != 0);
      ew_s = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) ns_d = $urandom_range(0, 6);
      if ($urandom_range(0, 7) == 0) ew_d = $urandom_range(0, 6);
`ifdef EMERGENCY_PREEMPT_EN
      if ($urandom_range(0, 24) == 0) preempt = ~preempt;
`endif
      tick();
    end
    preempt = 1'b0; ns_s = 1'b1; ew_s = 1'b1; ns_d = 5; ew_d = 5;
  endtask

`ifdef EMERGENCY_PREEMPT_EN
  task automatic test_preempt();
    int ylen, rlen;
    ew_d = 8;
    for (int i = 0; i < 80 && !(phase == 3'd4 && phase_done); i++) begin
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL pre_wait got=%b exp=%b", dut_vec, exp_vec());
      end
      tick();
    end
    tick();
    preempt = 1'b1;
    ylen = 0; rlen = 0;
    for (int i = 0; i < 30 && !(phase == 3'd1 && phase_done); i++) begin
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL pre_model cyc=%0d got=%b exp=%b", i, dut_vec, exp_vec());
      end
      if (phase == 3'd5) ylen++;
      if (phase == 3'd0) rlen++;
      if (i == 10) preempt = 1'b0;
      tick();
    end
    n_cmp++;
    if (ylen != 3 || rlen != 8 || phase !== 3'd1) begin
      n_err++; $display("FAIL pre_timing got y=%0d r=%0d ph=%0d exp y=3 r=8 ph=1", ylen, rlen, phase);
    end
    ew_d = 5;
    preempt = 1'b1;
    rst = 1'b1;
    #1 model_reset();
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL pre_reset cyc=%0d got=%b exp=%b", i, dut_vec, exp_vec());
      end
      if (i == 5) preempt = 1'b0;
      tick();
    end
    n_cmp++;
    if (phase !== 3'd1) begin
      n_err++; $display("FAIL pre_reset_resume got phase=%0d exp phase=1", phase);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_cycle();
    test_delay_change();
    test_zero_delay();
    test_rest_in_green();
    test_async_reset();
`ifdef EMERGENCY_PREEMPT_EN
    test_preempt();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/intersection_phase_sequencer.md
Name: intersection_phase_sequencer

Overview:
Sequences the two-way intersection through its signal phases, producing the NS and EW lamp drives. Consumes the per-direction green durations, in clock cycles, from the adaptive green-delay block. Inserts fixed yellow and all-red clearance intervals. Optionally rests in green while the opposing approach has no demand.

Parameters:
CLK_FREQ, 50_000_000, clock frequency in Hz
YELLOW_MS, 30, yellow interval in ms; YELLOW_CYC = YELLOW_MS*CLK_FREQ/1000
ALL_RED_MS, 10, all-red clearance in ms; ALL_RED_CYC derived the same way
REST_IN_GREEN, 1, 1 = hold green at expiry while the opposing sensor is low; 0 = always cycle
DELAY_W, 32, width of the green-delay inputs and the phase timer

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
ns_green_delay  in  DELAY_W  NS green length in cycles
ew_green_delay  in  DELAY_W  EW green length in cycles
ns_sensor  in  1  NS vehicle demand, level, synchronous to clk
ew_sensor  in  1  EW vehicle demand, level
ns_light  out  3  {red,yellow,green}, one-hot
ew_light  out  3  {red,yellow,green}, one-hot
phase  out  3  current state encoding
phase_done  out  1  one-cycle pulse on every state transition
preempt  in  1  present only with EMERGENCY_PREEMPT_EN

Behaviour:
- States and encodings: RED_TO_NS=0, NS_GREEN=1, NS_YELLOW=2, RED_TO_EW=3, EW_GREEN=4, EW_YELLOW=5. Codes 6 and 7 are illegal and go to RED_TO_NS on the next clock.
- Cycle order: RED_TO_NS -> NS_GREEN -> NS_YELLOW -> RED_TO_EW -> EW_GREEN -> EW_YELLOW -> RED_TO_NS.
- Reset, applied immediately and asynchronously, including mid-operation:
  - phase=RED_TO_NS
  - ns_light=ew_light=3'b100
  - phase_done=0
  - timer loaded with ALL_RED_CYC
- Timer: a down-counter loaded with N on the edge that enters a state. It decrements each cycle. The transition occurs on the edge where the counter equals 1, so each state lasts exactly N cycles.
- Load values:
  - Yellow states: YELLOW_CYC.
  - All-red states: ALL_RED_CYC.
  - Green states: the delay input sampled on the entry edge. A value of 0 is treated as 1. Input changes during green are ignored.
- Parameter-derived intervals of 0 are clamped to 1.
- Rest-in-green (REST_IN_GREEN=1):
  - When the green timer expires and the opposing sensor is low, the state holds with the counter at 0.
  - On the first cycle the opposing sensor is high, the next edge enters yellow.
  - If the opposing sensor is high at expiry, there is no extra cycle.
  - The own sensor has no effect.
- Outputs are registered and decoded from the state. Both directions show red in all-red states. Exactly one bit of each light bus is set at all times.
- phase_done is high for the first cycle of each new state. It does not pulse while resting in green.
- Safety invariant: the two directions are never both non-red in the same cycle.

Optional Feature:
EMERGENCY_PREEMPT_EN
- Defined:
  - Adds the preempt input.
  - preempt high in a green state forces the corresponding yellow on the next edge, with a full YELLOW_CYC interval. A yellow state in progress completes normally.
  - The block then enters the following all-red state and holds it, timer frozen, while preempt is high.
  - When preempt falls, the all-red state runs a full ALL_RED_CYC and the cycle resumes with the next green.
  - preempt held through reset takes effect after reset release.
- Undefined: the port is absent and the behaviour is exactly as above.

Decomposition:
- traffic_pkg:
  - state encoding localparams
  - light encodings LIGHT_RED=3'b100, LIGHT_YEL=3'b010, LIGHT_GRN=3'b001
  - function ms_to_cycles(ms, clk_freq) with clamp to at least 1
- Sub-module phase_timer (DELAY_W):
  - inputs: load, load_val, hold
  - outputs: count and expire, where expire = (count==1) and not hold
  - load takes priority over hold

Test Plan:
All tests use CLK_FREQ=1000, YELLOW_MS=3, ALL_RED_MS=2.
1. Release reset with ns/ew delay=5 and both sensors high -> RED_TO_NS 2 cycles, NS_GREEN 5, NS_YELLOW 3, RED_TO_EW 2, EW_GREEN 5, EW_YELLOW 3. phase_done pulses at each entry; the full cycle is 20 cycles.
2. Change ns_green_delay from 5 to 9 on the third cycle of NS_GREEN -> the current green still lasts 5 cycles; the next NS_GREEN lasts 9.
3. With ew_green_delay=0 -> EW_GREEN lasts exactly 1 cycle.
4. REST_IN_GREEN=1, ew_sensor low, ns_delay=4 -> NS stays green indefinitely with no phase_done. Raise ew_sensor at cycle 20 -> NS_YELLOW on the next edge.
5. Assert rst mid NS_YELLOW -> lights go to 100/100 and phase to 0 in the same cycle without a clock edge. After release, a 2-cycle all-red precedes NS_GREEN.
6. With EMERGENCY_PREEMPT_EN, pulse preempt for 10 cycles during EW_GREEN -> 3 yellow cycles, then all-red held for the remaining preempt time plus 2 cycles, then NS_GREEN.
